// File: rtl/dh_pkg.sv
// Shared types, product-operand select tables and fixed-point helpers for the
// Denavit-Hartenberg transform generator.
package dh_pkg;

  typedef enum logic {DH_STD = 1'b0, DH_MOD = 1'b1} dh_mode_e;

  typedef enum logic [1:0] {StIdle, StMul, StDone} dh_state_e;

  typedef enum logic [2:0] {OpSt, OpCt, OpSa, OpCa, OpA, OpD} dh_opnd_e;

  localparam int unsigned DefFrac = 16;
  localparam int unsigned NumProd = 6;

  // One product: two latched operands, destination entry, negate after shift.
  typedef struct packed {
    dh_opnd_e   lhs;
    dh_opnd_e   rhs;
    logic [1:0] row;
    logic [1:0] col;
    logic       neg;
  } dh_prod_t;

  localparam dh_prod_t StdProdTbl [NumProd] = '{
    '{lhs: OpSt, rhs: OpCa, row: 2'd0, col: 2'd1, neg: 1'b1},
    '{lhs: OpSt, rhs: OpSa, row: 2'd0, col: 2'd2, neg: 1'b0},
    '{lhs: OpA,  rhs: OpCt, row: 2'd0, col: 2'd3, neg: 1'b0},
    '{lhs: OpCt, rhs: OpCa, row: 2'd1, col: 2'd1, neg: 1'b0},
    '{lhs: OpCt, rhs: OpSa, row: 2'd1, col: 2'd2, neg: 1'b1},
    '{lhs: OpA,  rhs: OpSt, row: 2'd1, col: 2'd3, neg: 1'b0}
  };

  localparam dh_prod_t ModProdTbl [NumProd] = '{
    '{lhs: OpSt, rhs: OpCa, row: 2'd1, col: 2'd0, neg: 1'b0},
    '{lhs: OpCt, rhs: OpCa, row: 2'd1, col: 2'd1, neg: 1'b0},
    '{lhs: OpSt, rhs: OpSa, row: 2'd2, col: 2'd0, neg: 1'b0},
    '{lhs: OpCt, rhs: OpSa, row: 2'd2, col: 2'd1, neg: 1'b0},
    '{lhs: OpSa, rhs: OpD,  row: 2'd1, col: 2'd3, neg: 1'b1},
    '{lhs: OpCa, rhs: OpD,  row: 2'd2, col: 2'd3, neg: 1'b0}
  };

  // Fixed-point constant one; zero if FRAC cannot be represented in W bits.
  function automatic logic [63:0] fx_one(int unsigned w, int unsigned frac);
    return (frac < w && frac < 63) ? (64'd1 << frac) : 64'd0;
  endfunction

endpackage

// File: rtl/dh_fxmul.sv
// Combinational signed fixed-point multiply: full-width product, floor shift
// by FRAC, sign-extended (or narrowed) to the W-bit output.
module dh_fxmul #(
  parameter int unsigned AW   = 21,
  parameter int unsigned W    = 36,
  parameter int unsigned FRAC = 16
) (
  input  logic signed [AW-1:0] a_i,
  input  logic signed [AW-1:0] b_i,
  output logic signed [W-1:0]  p_o
);

  logic signed [2*AW-1:0] prod;
  logic signed [2*AW-1:0] shifted;

  assign prod    = a_i * b_i;
  assign shifted = prod >>> FRAC;
  assign p_o     = W'(shifted);

endmodule

// File: rtl/dh_t_matrix_gen.sv
// Builds one 4x4 homogeneous DH transform per accepted joint, standard or
// modified convention, using NMUL time-multiplexed fixed-point multipliers.
module dh_t_matrix_gen
  import dh_pkg::*;
#(
  parameter int unsigned AW   = 21,
  parameter int unsigned W    = 36,
  parameter int unsigned FRAC = DefFrac,
  parameter int unsigned NMUL = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       en_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic                       mode_i,
  input  logic signed [AW-1:0]       sin_theta_i,
  input  logic signed [AW-1:0]       cos_theta_i,
  input  logic signed [AW-1:0]       sin_alpha_i,
  input  logic signed [AW-1:0]       cos_alpha_i,
  input  logic signed [AW-1:0]       a_i,
  input  logic signed [AW-1:0]       d_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [3:0][3:0][W-1:0]     t_matrix_o
);

  if (!(NMUL == 1 || NMUL == 2 || NMUL == 3 || NMUL == 6)) begin : g_bad_nmul
    $error("dh_t_matrix_gen: NMUL must be 1, 2, 3 or 6");
  end
  if (W < 2 * AW - FRAC + 1) begin : g_bad_width
    $error("dh_t_matrix_gen: W too small for shifted product");
  end

  localparam logic [W-1:0] One   = W'(fx_one(W, FRAC));
  localparam logic [2:0]   KStep = 3'(NMUL);
  localparam logic [2:0]   LastK = 3'(NumProd - NMUL);

  dh_state_e               state_q, state_d;
  logic [2:0]              k_q, k_d;
  dh_mode_e                mode_q, mode_d;
  logic signed [AW-1:0]    opnd_q [NumProd];
  logic signed [AW-1:0]    opnd_d [NumProd];
  logic [3:0][3:0][W-1:0]  mat_q, mat_d;
  logic [3:0][3:0][W-1:0]  base;
  logic                    accept;
  logic                    load;

  dh_prod_t                prod_sel [NMUL];
  logic signed [W-1:0]     prod     [NMUL];

  assign in_ready_o  = !rst_i && (state_q == StIdle || (state_q == StDone && out_ready_i));
  assign out_valid_o = (state_q == StDone);
  assign t_matrix_o  = mat_q;
  assign accept      = en_i && in_valid_i && in_ready_o;

  for (genvar i = 0; i < NMUL; i++) begin : g_mul
    logic [2:0] idx;
    assign idx         = k_q + 3'(i);
    assign prod_sel[i] = (mode_q == DH_MOD) ? ModProdTbl[idx] : StdProdTbl[idx];

    dh_fxmul #(
      .AW   (AW),
      .W    (W),
      .FRAC (FRAC)
    ) u_fxmul (
      .a_i (opnd_q[prod_sel[i].lhs]),
      .b_i (opnd_q[prod_sel[i].rhs]),
      .p_o (prod[i])
    );
  end

  // Entries that need no multiply, written on the accept edge; product slots start at 0.
  always_comb begin
    base       = '0;
    base[3][3] = One;
    base[0][0] = W'(cos_theta_i);
    base[2][2] = W'(cos_alpha_i);
    if (mode_i == 1'b0) begin
      base[1][0] = W'(sin_theta_i);
      base[2][1] = W'(sin_alpha_i);
      base[2][3] = W'(d_i);
    end else begin
      base[0][1] = -W'(sin_theta_i);
      base[0][3] = W'(a_i);
      base[1][2] = -W'(sin_alpha_i);
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    mode_d  = mode_q;
    opnd_d  = opnd_q;
    mat_d   = mat_q;
    load    = 1'b0;
    case (state_q)
      StIdle: load = accept;
      StMul: begin
        for (int i = 0; i < NMUL; i++) begin
          mat_d[prod_sel[i].row][prod_sel[i].col] = prod_sel[i].neg ? -prod[i] : prod[i];
        end
        if (k_q == LastK) begin
          state_d = StDone;
          k_d     = '0;
        end else begin
          k_d = k_q + KStep;
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
          load    = accept;
        end
      end
      default: state_d = StIdle;
    endcase
    if (load) begin
      state_d      = StMul;
      k_d          = '0;
      mode_d       = dh_mode_e'(mode_i);
      opnd_d[OpSt] = sin_theta_i;
      opnd_d[OpCt] = cos_theta_i;
      opnd_d[OpSa] = sin_alpha_i;
      opnd_d[OpCa] = cos_alpha_i;
      opnd_d[OpA]  = a_i;
      opnd_d[OpD]  = d_i;
      mat_d        = base;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      k_q     <= '0;
      mode_q  <= DH_STD;
      mat_q   <= '0;
      for (int j = 0; j < NumProd; j++) begin
        opnd_q[j] <= '0;
      end
    end else if (en_i) begin
      state_q <= state_d;
      k_q     <= k_d;
      mode_q  <= mode_d;
      mat_q   <= mat_d;
      for (int j = 0; j < NumProd; j++) begin
        opnd_q[j] <= opnd_d[j];
      end
    end
  end

endmodule

// File: tb/tb_dh_t_matrix_gen.sv
// Scoreboard bench for dh_t_matrix_gen; one instance per legal NMUL, exercised in turn.
module tb_dh_t_matrix_gen;

  typedef logic [3:0][3:0][35:0] mat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst       [4];
  logic               en        [4];
  logic               in_valid  [4];
  logic               out_ready [4];
  logic               in_ready  [4];
  logic               out_valid [4];
  mat_t               tm        [4];
  logic               mode;
  logic signed [20:0] st, ct, sa, ca, av, dv;

  int unsigned nm_tbl [4] = '{2, 1, 3, 6};
  int   cur   = 0;
  int   n_chk = 0;
  int   n_err = 0;
  mat_t exp_q [$];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned Nm = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 3 : 6;
    dh_t_matrix_gen #(
      .AW   (21),
      .W    (36),
      .FRAC (16),
      .NMUL (Nm)
    ) u_dut (
      .clk_i       (clk),
      .rst_i       (rst[g]),
      .en_i        (en[g]),
      .in_valid_i  (in_valid[g]),
      .in_ready_o  (in_ready[g]),
      .mode_i      (mode),
      .sin_theta_i (st),
      .cos_theta_i (ct),
      .sin_alpha_i (sa),
      .cos_alpha_i (ca),
      .a_i         (av),
      .d_i         (dv),
      .out_valid_o (out_valid[g]),
      .out_ready_i (out_ready[g]),
      .t_matrix_o  (tm[g])
    );
  end

  task automatic chk(input string tag, input logic [575:0] got, input logic [575:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s nmul=%0d got=%0h exp=%0h", tag, nm_tbl[cur], got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint mulf(longint x, longint y);
    return (x * y) >>> 16;
  endfunction

  function automatic logic [35:0] fx(longint v);
    return v[35:0];
  endfunction

  function automatic mat_t golden(bit m, longint s_t, longint c_t, longint s_a, longint c_a,
                                  longint la, longint ld);
    mat_t r;
    r       = '0;
    r[3][3] = fx(65536);
    if (!m) begin
      r[0][0] = fx(c_t);            r[0][1] = fx(-mulf(s_t, c_a));
      r[0][2] = fx(mulf(s_t, s_a)); r[0][3] = fx(mulf(la, c_t));
      r[1][0] = fx(s_t);            r[1][1] = fx(mulf(c_t, c_a));
      r[1][2] = fx(-mulf(c_t, s_a)); r[1][3] = fx(mulf(la, s_t));
      r[2][1] = fx(s_a);            r[2][2] = fx(c_a);
      r[2][3] = fx(ld);
    end else begin
      r[0][0] = fx(c_t);            r[0][1] = fx(-s_t);
      r[0][3] = fx(la);
      r[1][0] = fx(mulf(s_t, c_a)); r[1][1] = fx(mulf(c_t, c_a));
      r[1][2] = fx(-s_a);           r[1][3] = fx(-mulf(s_a, ld));
      r[2][0] = fx(mulf(s_t, s_a)); r[2][1] = fx(mulf(c_t, s_a));
      r[2][2] = fx(c_a);            r[2][3] = fx(mulf(c_a, ld));
    end
    return r;
  endfunction

  function automatic longint rnd(longint span);
    return longint'($urandom_range(32'd0, 32'(2 * span))) - span;
  endfunction

  task automatic drive(input bit m, input longint vst, input longint vct, input longint vsa,
                       input longint vca, input longint va, input longint vd);
    mode = m;
    st   = 21'(vst);
    ct   = 21'(vct);
    sa   = 21'(vsa);
    ca   = 21'(vca);
    av   = 21'(va);
    dv   = 21'(vd);
  endtask

  // Returns just after the accept edge.
  task automatic send(input bit m, input longint vst, input longint vct, input longint vsa,
                      input longint vca, input longint va, input longint vd, input bit push);
    int c;
    drive(m, vst, vct, vsa, vca, va, vd);
    in_valid[cur] = 1'b1;
    #1;
    c = 0;
    while (!in_ready[cur] && c < 50) begin
      step();
      c++;
    end
    chk("accept_ready", 576'(in_ready[cur]), 576'(1));
    if (push) exp_q.push_back(golden(m, vst, vct, vsa, vca, va, vd));
    step();
    in_valid[cur] = 1'b0;
  endtask

  task automatic wait_valid(input int lat, input string tag);
    int c;
    c = 0;
    while (!out_valid[cur] && c < 40) begin
      step();
      c++;
    end
    chk(tag, 576'(c), 576'(lat));
  endtask

  always @(negedge clk) begin
    if (!rst[cur] && en[cur] && out_valid[cur] && out_ready[cur]) begin
      if (exp_q.size() == 0) chk("sb_underflow", 576'(exp_q.size()), 576'(1));
      else chk("sb_matrix", tm[cur], exp_q.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog n_chk=%0d", n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    mat_t e1, e2;
    int   lat;
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1; en[i] = 1'b1; in_valid[i] = 1'b0; out_ready[i] = 1'b1;
    end
    drive(1'b0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
    for (int n = 0; n < 4; n++) begin
      cur = n;
      lat = 6 / int'(nm_tbl[n]);
      rst[n] = 1'b1;
      step();
      rst[n] = 1'b0;
      #1;
      chk("reset_valid", 576'(out_valid[n]), 576'(0));
      chk("reset_ready", 576'(in_ready[n]), 576'(1));
      chk("reset_tm", tm[n], '0);

      // Standard, theta=90, alpha=0; held under backpressure.
      e1 = '0;
      e1[0][1] = fx(-65536); e1[1][0] = fx(65536); e1[1][3] = fx(65536);
      e1[2][2] = fx(65536);  e1[2][3] = fx(131072); e1[3][3] = fx(65536);
      out_ready[n] = 1'b0;
      send(1'b0, 65536, 0, 0, 65536, 65536, 131072, 1'b0);
      exp_q.push_back(e1);
      wait_valid(lat, "lat_std");
      // Modified, theta=0, alpha=90 waits at the input meanwhile.
      e2 = '0;
      e2[0][0] = fx(65536);   e2[0][3] = fx(65536);  e2[1][2] = fx(-65536);
      e2[1][3] = fx(-131072); e2[2][1] = fx(65536);  e2[3][3] = fx(65536);
      drive(1'b1, 0, 65536, 65536, 0, 65536, 131072);
      in_valid[n] = 1'b1;
      for (int c = 0; c < 10; c++) begin
        chk("bp_valid", 576'(out_valid[n]), 576'(1));
        chk("bp_ready", 576'(in_ready[n]), 576'(0));
        chk("bp_tm", tm[n], e1);
        step();
      end
      out_ready[n] = 1'b1;
      #1;
      chk("b2b_ready", 576'(in_ready[n]), 576'(1));
      exp_q.push_back(e2);
      step();
      in_valid[n] = 1'b0;
      chk("b2b_valid", 576'(out_valid[n]), 576'(0));
      chk("b2b_no_idle", 576'(in_ready[n]), 576'(0));
      wait_valid(lat, "lat_mod");
      step();

      // Floor then negate: -1 * 0.5 floors to -1, entry becomes +1.
      send(1'b0, -1, 65536, 0, 32768, 0, 0, 1'b1);
      wait_valid(lat, "lat_floor");
      chk("floor_01", 576'(tm[n][0][1]), 576'(fx(1)));
      step();

      for (int r = 0; r < 4; r++) begin
        send(r[0], rnd(65536), rnd(65536), rnd(65536), rnd(65536), rnd(1048575), rnd(1048575),
             1'b1);
        wait_valid(lat, "lat_rand");
        step();
      end

      // Clock-enable stall mid-sequence.
      send(1'b1, rnd(65536), rnd(65536), rnd(65536), rnd(65536), rnd(1048575), rnd(1048575),
           1'b1);
      if (lat > 1) step();
      en[n] = 1'b0;
      repeat (4) step();
      chk("stall_hold", 576'(out_valid[n]), 576'(0));
      en[n] = 1'b1;
      wait_valid((lat > 1) ? lat - 1 : lat, "lat_stall");
      step();

      // Reset mid-sequence discards the partial matrix.
      send(1'b0, rnd(65536), rnd(65536), rnd(65536), rnd(65536), rnd(1048575), rnd(1048575),
           1'b0);
      if (lat > 1) step();
      rst[n] = 1'b1;
      #1;
      chk("abort_ready", 576'(in_ready[n]), 576'(0));
      step();
      chk("abort_valid", 576'(out_valid[n]), 576'(0));
      chk("abort_tm", tm[n], '0);
      rst[n] = 1'b0;
      step();
      chk("abort_idle", 576'(in_ready[n]), 576'(1));
      chk("sb_drain", 576'(exp_q.size()), 576'(0));
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
